// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front end: FSM states and word geometry.
// Optional feature macro: MAU_BOUNDS_CHECK_EN (word index >= MEM_SIZE returns an error).
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam int WORD_BYTES = 8;
    localparam int WORD_SHIFT = 3;

`ifdef MAU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK_EN = 1'b1;
`else
    localparam bit BOUNDS_CHECK_EN = 1'b0;
`endif

endpackage

// File: rtl/mau_addr_check.sv
// Combinational address decode: byte address -> word index plus misalign/out-of-range flag.
// Range flagging is active only when MAU_BOUNDS_CHECK_EN is defined (see mem_pkg).
module mau_addr_check
    import mem_pkg::*;
#(
    parameter int MEM_SIZE   = 262144,
    parameter int BIT_NUMBER = 32
) (
    input  logic [BIT_NUMBER-1:0] addr,
    output logic [BIT_NUMBER-1:0] word_idx,
    output logic                  err
);

    localparam logic [BIT_NUMBER:0] MEM_SIZE_W = (BIT_NUMBER + 1)'(MEM_SIZE);

    logic misaligned;
    logic out_of_range;

    always_comb begin
        word_idx     = addr >> WORD_SHIFT;
        misaligned   = (addr[WORD_SHIFT-1:0] != '0);
        // Without the bounds check the memory simply ignores the upper index bits.
        out_of_range = BOUNDS_CHECK_EN && ({1'b0, word_idx} >= MEM_SIZE_W);
        err          = misaligned | out_of_range;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end driving a registered data memory, one request outstanding at a time.
// Optional feature macro: MAU_BOUNDS_CHECK_EN (handled in mem_pkg / mau_addr_check).
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_SIZE    = 262144,
    parameter int BIT_NUMBER  = 32,
    parameter int VECTOR_SIZE = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [BIT_NUMBER-1:0]  req_addr,
    input  logic [VECTOR_SIZE-1:0] req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [VECTOR_SIZE-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   mem_enable,
    output logic                   mem_we,
    output logic [BIT_NUMBER-1:0]  mem_address,
    output logic [VECTOR_SIZE-1:0] mem_data_in,
    input  logic [VECTOR_SIZE-1:0] mem_data_out
);

    state_e                 state_q, state_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [VECTOR_SIZE-1:0] resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;
    logic                   mem_enable_q, mem_enable_d;
    logic                   mem_we_q, mem_we_d;
    logic [BIT_NUMBER-1:0]  mem_address_q, mem_address_d;
    logic [VECTOR_SIZE-1:0] mem_data_in_q, mem_data_in_d;

    logic [BIT_NUMBER-1:0]  word_idx;
    logic                   addr_err;

    mau_addr_check #(
        .MEM_SIZE   (MEM_SIZE),
        .BIT_NUMBER (BIT_NUMBER)
    ) u_addr_check (
        .addr     (req_addr),
        .word_idx (word_idx),
        .err      (addr_err)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d       = state_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    resp_rdata_d = '0;
                    resp_err_d   = addr_err;
                    if (addr_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d       = ISSUE;
                        mem_address_d = word_idx;
                        mem_data_in_d = req_wdata;
                    end
                end
            end
            // mem_we_q is high during ISSUE exactly when the request is a store.
            ISSUE: begin
                if (mem_we_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                resp_rdata_d = mem_data_out;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        mem_enable_d = (state_d == ISSUE);
        mem_we_d     = (state_d == ISSUE) && req_write;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_enable_q  <= mem_enable_d;
            mem_we_q      <= mem_we_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_enable  = mem_enable_q;
    assign mem_we      = mem_we_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random loads/stores
// checked against a word-addressed reference memory and latency/alignment rules.
module tb_mem_access_unit;

    localparam int MEM_SIZE    = 262144;
    localparam int BIT_NUMBER  = 32;
    localparam int VECTOR_SIZE = 64;

`ifdef MAU_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   req_valid, req_ready, req_write;
    logic [BIT_NUMBER-1:0]  req_addr;
    logic [VECTOR_SIZE-1:0] req_wdata;
    logic                   resp_valid, resp_ready;
    logic [VECTOR_SIZE-1:0] resp_rdata;
    logic                   resp_err;
    logic                   mem_enable, mem_we;
    logic [BIT_NUMBER-1:0]  mem_address;
    logic [VECTOR_SIZE-1:0] mem_data_in;
    logic [VECTOR_SIZE-1:0] mem_data_out = '0;

    int n_vec  = 0;
    int n_miss = 0;

    // Environment memory (what the DUT talks to) and the independent reference contents.
    bit [63:0] env_mem [bit [31:0]];
    bit [63:0] ref_mem [bit [31:0]];

    mem_access_unit #(
        .MEM_SIZE    (MEM_SIZE),
        .BIT_NUMBER  (BIT_NUMBER),
        .VECTOR_SIZE (VECTOR_SIZE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_enable   (mem_enable),
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_we) env_mem[mem_address % MEM_SIZE] = mem_data_in;
            else        mem_data_out <= env_mem.exists(mem_address % MEM_SIZE) ?
                                        env_mem[mem_address % MEM_SIZE] : 64'd0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".resp_valid"},  64'(resp_valid),  64'd0);
        check({tag, ".resp_rdata"},  resp_rdata,       64'd0);
        check({tag, ".resp_err"},    64'(resp_err),    64'd0);
        check({tag, ".mem_enable"},  64'(mem_enable),  64'd0);
        check({tag, ".mem_we"},      64'(mem_we),      64'd0);
        check({tag, ".mem_address"}, 64'(mem_address), 64'd0);
        check({tag, ".mem_data_in"}, mem_data_in,      64'd0);
        check({tag, ".req_ready"},   64'(req_ready),   64'd0);
    endtask

    // One full transaction: handshake, watch the memory port, check the response,
    // hold resp_ready low for 'hold' cycles while offering a competing request.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [63:0] wdata,
                          input int hold);
        logic [31:0] idx;
        bit          err;
        int          exp_lat;
        logic [63:0] exp_rdata;
        int          lat, en_cnt, guard;
        logic [31:0] seen_addr;
        logic        seen_we;
        logic [63:0] seen_din;

        idx       = addr >> 3;
        err       = (addr % 8 != 0) || (BOUNDS && idx >= MEM_SIZE);
        exp_lat   = err ? 1 : (wr ? 2 : 3);
        exp_rdata = 64'd0;
        if (!err && !wr && ref_mem.exists(idx % MEM_SIZE)) exp_rdata = ref_mem[idx % MEM_SIZE];

        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b0;
        @(posedge clk);

        lat = 0; en_cnt = 0; seen_addr = '0; seen_we = 1'b0; seen_din = '0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mem_enable) begin
                en_cnt++;
                seen_addr = mem_address;
                seen_we   = mem_we;
                seen_din  = mem_data_in;
            end
        end while (!resp_valid && lat < 8);

        check("latency",       64'(lat),       64'(exp_lat));
        check("enable_cycles", 64'(en_cnt),    err ? 64'd0 : 64'd1);
        if (!err) begin
            check("mem_address", 64'(seen_addr), 64'(idx));
            check("mem_we",      64'(seen_we),   64'(wr));
            if (wr) check("mem_data_in", seen_din, wdata);
        end
        check("resp_err",   64'(resp_err), 64'(err));
        check("resp_rdata", resp_rdata,    exp_rdata);
        check("req_ready_busy", 64'(req_ready), 64'd0);

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'($urandom_range(0, 15)) << 3;
            req_wdata = {$urandom, $urandom};
            @(negedge clk);
            check("hold_valid",  64'(resp_valid), 64'd1);
            check("hold_rdata",  resp_rdata,      exp_rdata);
            check("hold_err",    64'(resp_err),   64'(err));
            check("hold_ready",  64'(req_ready),  64'd0);
            check("hold_enable", 64'(mem_enable), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_drop",  64'(resp_valid), 64'd0);
        check("back_ready", 64'(req_ready),  64'd1);

        if (!err && wr) ref_mem[idx % MEM_SIZE] = wdata;
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        #1 check("ready_before_edge", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("ready_after_edge", 64'(req_ready), 64'd1);

        // Directed: store, load back, misaligned load, long back-pressure.
        do_req(1'b1, 32'h40, 64'h1122334455667788, 0);
        do_req(1'b0, 32'h40, 64'd0, 0);
        do_req(1'b0, 32'h43, 64'd0, 0);
        do_req(1'b0, 32'h40, 64'd0, 10);

        // Reset during ISSUE of a store: write must be dropped.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("issue_enable", 64'(mem_enable), 64'd1);
        reset = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_req(1'b0, 32'h40, 64'd0, 0);

        // Index one past the last word: error with bounds check, plain access otherwise.
        do_req(1'b0, 32'(MEM_SIZE * 8), 64'd0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] idx;
            logic [31:0] a;
            idx = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) idx = idx + 32'($urandom_range(1, 3)) * MEM_SIZE;
            a = idx << 3;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 7));
            do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
